io_seg_display: RTL and testbench

Output-side peripheral for the pipelined computer's memory-mapped I/O. It consumes the four 32-bit output-port values the CPU writes and shows each one on a pair of 7-segment digits as a two-digit decimal number. On any change it takes a snapshot of the ports and converts each one with a sequential shift-add-3 (double-dabble) engine. All eight digits then update together in a single commit. It sits between the CPU top's output ports and the board's HEX displays.

---
 rtl/io_seg_display.sv | 184 ++++++++++++++++++
 tb/tb_io_seg_display.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_seg_display.sv
// io_seg_display
// ---------------------------------------------------------------------------
// Shows the low 7 bits of four CPU output ports as two-digit decimal numbers
// on eight 7-segment displays. Any port change (or the first cycle after
// reset) snapshots all four ports. Each snapshot is then converted serially
// by a single shift-add-3 engine, and all eight digits are committed together.
//
// Ports
//   clock          system clock, rising edge
//   reset          synchronous, active-high
//   port0..port3   CPU output-port values; only bits [6:0] are displayed
//   hex0..hex7     active-low segments {g,f,e,d,c,b,a}; hex(2k)=ones of
//                  port k, hex(2k+1)=tens of port k
//   ovf            ovf[k]=1 when port k[6:0] >= 100 (digits show value mod 100)
//   busy           conversion status, see below
//
// Update protocol: busy is high while a snapshot is being converted or
// committed. The hex/ovf outputs change only on the edge where busy falls,
// and all of them change on that one edge. The outputs are stable whenever
// busy is high or low for more than one cycle. There is no back-pressure.
// ---------------------------------------------------------------------------
module io_seg_display #(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] port0,
  input  logic [31:0] port1,
  input  logic [31:0] port2,
  input  logic [31:0] port3,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [6:0]  hex6,
  output logic [6:0]  hex7,
  output logic [3:0]  ovf,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  state_t      state_q;
  logic        pending_q;
  logic [6:0]  snap_q      [4];
  logic [6:0]  bin_q;
  logic [11:0] bcd_q;
  logic [1:0]  idx_q;
  logic [2:0]  cnt_q;
  logic [6:0]  stage_hex_q [8];
  logic [3:0]  stage_ovf_q;
  logic [6:0]  hex_q       [8];
  logic [3:0]  ovf_q;

  logic [6:0]  port_lo     [4];
  logic        start;
  logic [11:0] bcd_adj;
  logic [11:0] bcd_d;
  logic [6:0]  bin_d;
  logic [6:0]  ones_seg;
  logic [6:0]  tens_seg;
  logic        ovf_bit;

  // The upper port bits carry nothing this block displays.
  logic unused_port_hi;
  assign unused_port_hi = ^{port0[31:7], port1[31:7], port2[31:7], port3[31:7]};

  assign port_lo[0] = port0[6:0];
  assign port_lo[1] = port1[6:0];
  assign port_lo[2] = port2[6:0];
  assign port_lo[3] = port3[6:0];

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  always_comb begin
    start = pending_q ||
            (port_lo[0] != snap_q[0]) || (port_lo[1] != snap_q[1]) ||
            (port_lo[2] != snap_q[2]) || (port_lo[3] != snap_q[3]);

    // One double-dabble step: add 3 to every nibble >= 5, then shift the
    // next binary MSB into the BCD accumulator.
    bcd_adj = bcd_q;
    for (int n = 0; n < 3; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    end
    bcd_d = {bcd_adj[10:0], bin_q[6]};
    bin_d = {bin_q[5:0], 1'b0};

    // Digit codes are decoded from the post-shift value, so the last shift
    // and the staging write happen on the same edge.
    ones_seg = seg7(bcd_d[3:0]);
    tens_seg = (BLANK_LZ && (bcd_d[7:4] == 4'd0)) ? SEG_BLANK : seg7(bcd_d[7:4]);
    ovf_bit  = (bcd_d[11:8] != 4'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pending_q   <= 1'b1;
      bin_q       <= '0;
      bcd_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      stage_ovf_q <= '0;
      ovf_q       <= '0;
      for (int i = 0; i < 4; i++) snap_q[i] <= '0;
      for (int i = 0; i < 8; i++) begin
        stage_hex_q[i] <= SEG_BLANK;
        hex_q[i]       <= SEG_BLANK;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            snap_q    <= port_lo;
            pending_q <= 1'b0;
            bin_q     <= port_lo[0];
            bcd_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            state_q   <= S_CONV;
          end
        end
        S_CONV: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd6) begin
            stage_hex_q[{idx_q, 1'b0}] <= ones_seg;
            stage_hex_q[{idx_q, 1'b1}] <= tens_seg;
            stage_ovf_q[idx_q]         <= ovf_bit;
            if (idx_q != 2'd3) begin
              // Next port comes from the snapshot, not the live inputs.
              idx_q <= idx_q + 2'd1;
              bin_q <= snap_q[idx_q + 2'd1];
              bcd_q <= '0;
              cnt_q <= '0;
            end else begin
              state_q <= S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          hex_q   <= stage_hex_q;
          ovf_q   <= stage_ovf_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
  assign hex6 = hex_q[6];
  assign hex7 = hex_q[7];
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_io_seg_display.sv
// Bench for io_seg_display: one instance with default leading-zero blanking
// and one with BLANK_LZ=0, both fed by the same ports. Expected display words
// {ovf, hex7..hex0} are queued when stimulus is applied and popped by a
// monitor on each commit (busy falling outside reset).
module tb_io_seg_display;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [31:0] port0, port1, port2, port3;

  logic [6:0] a_hex0, a_hex1, a_hex2, a_hex3, a_hex4, a_hex5, a_hex6, a_hex7;
  logic [6:0] b_hex0, b_hex1, b_hex2, b_hex3, b_hex4, b_hex5, b_hex6, b_hex7;
  logic [3:0] a_ovf, b_ovf;
  logic       a_busy, b_busy;
  logic [59:0] a_word, b_word;

  assign a_word = {a_ovf, a_hex7, a_hex6, a_hex5, a_hex4, a_hex3, a_hex2, a_hex1, a_hex0};
  assign b_word = {b_ovf, b_hex7, b_hex6, b_hex5, b_hex4, b_hex3, b_hex2, b_hex1, b_hex0};

  io_seg_display dut (
    .clock(clock), .reset(reset),
    .port0(port0), .port1(port1), .port2(port2), .port3(port3),
    .hex0(a_hex0), .hex1(a_hex1), .hex2(a_hex2), .hex3(a_hex3),
    .hex4(a_hex4), .hex5(a_hex5), .hex6(a_hex6), .hex7(a_hex7),
    .ovf(a_ovf), .busy(a_busy)
  );

  io_seg_display #(.BLANK_LZ(1'b0)) dut_nlz (
    .clock(clock), .reset(reset),
    .port0(port0), .port1(port1), .port2(port2), .port3(port3),
    .hex0(b_hex0), .hex1(b_hex1), .hex2(b_hex2), .hex3(b_hex3),
    .hex4(b_hex4), .hex5(b_hex5), .hex6(b_hex6), .hex7(b_hex7),
    .ovf(b_ovf), .busy(b_busy)
  );

  // ---------------- scoreboard ----------------
  localparam logic [6:0]  BL = 7'h7F;
  localparam logic [59:0] ALL_BLANK = {4'h0, {8{7'h7F}}};

  logic [6:0]  seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};
  logic [59:0] exp_q[$];
  logic [59:0] exp2_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic        a_busy_prev = 1'b0;
  logic        b_busy_prev = 1'b0;

  task automatic check(input string name, input logic [59:0] act, input logic [59:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Decimal reference: value mod 100 split with / and %.
  function automatic logic [59:0] exp_word(input logic [31:0] p0, input logic [31:0] p1,
                                           input logic [31:0] p2, input logic [31:0] p3,
                                           input bit blz);
    logic [31:0] p [4];
    logic [59:0] w;
    int v, ones, tens;
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      v    = int'(p[k][6:0]);
      ones = (v % 100) % 10;
      tens = (v % 100) / 10;
      w[14*k +: 7]     = seg_tab[ones];
      w[14*k + 7 +: 7] = (blz && tens == 0) ? BL : seg_tab[tens];
      w[56 + k]        = (v >= 100);
    end
    return w;
  endfunction

  task automatic push_exp();
    exp_q.push_back(exp_word(port0, port1, port2, port3, 1'b1));
    exp2_q.push_back(exp_word(port0, port1, port2, port3, 1'b0));
  endtask

  // ---------------- monitors ----------------
  always @(negedge clock) begin
    if (!reset && a_busy_prev && !a_busy) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL commit_a: got %h, expected no commit", a_word);
      end else begin
        check("commit_a", a_word, exp_q.pop_front());
      end
    end
    a_busy_prev <= a_busy;
  end

  always @(negedge clock) begin
    if (!reset && b_busy_prev && !b_busy) begin
      if (exp2_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL commit_b: got %h, expected no commit", b_word);
      end else begin
        check("commit_b", b_word, exp2_q.pop_front());
      end
    end
    b_busy_prev <= b_busy;
  end

  // ---------------- driver tasks ----------------
  // Waits for busy to rise, then counts edges from E0 through the commit
  // edge E29 inclusive (30 for one full update). Returns at the negedge
  // after the commit.
  task automatic wait_update(output int edges);
    int t;
    t = 0;
    edges = 0;
    while (!a_busy && t < 5) begin
      @(negedge clock);
      t++;
    end
    if (!a_busy) begin
      n_vec++; n_bad++;
      $display("FAIL busy_rise: got busy=0, expected busy=1 within 5 cycles");
      return;
    end
    edges = 1;
    while (a_busy && edges < 60) begin
      @(negedge clock);
      edges++;
    end
    if (a_busy) begin
      n_vec++; n_bad++;
      $display("FAIL busy_fall: got busy=1 after %0d edges, expected commit", edges);
    end
  endtask

  task automatic set_ports(input logic [31:0] p0, input logic [31:0] p1,
                           input logic [31:0] p2, input logic [31:0] p3);
    @(posedge clock);
    #1;
    port0 = p0; port1 = p1; port2 = p2; port3 = p3;
  endtask

  // ---------------- stimulus ----------------
  int edges;

  initial begin
    reset = 1'b1;
    port0 = '0; port1 = '0; port2 = '0; port3 = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_hex_a", a_word, ALL_BLANK);
    check("reset_hex_b", b_word, ALL_BLANK);
    check("reset_busy", {59'd0, a_busy}, 60'd0);

    // Forced conversion after reset, all ports 0.
    push_exp();
    @(posedge clock);
    #1 reset = 1'b0;
    wait_update(edges);
    check("first_edges", 60'(edges), 60'd30);
    check("first_word", a_word, {4'h0, BL, 7'b1000000, BL, 7'b1000000,
                                 BL, 7'b1000000, BL, 7'b1000000});

    // 42, 7, 99, 10.
    set_ports(32'd42, 32'd7, 32'd99, 32'd10);
    push_exp();
    wait_update(edges);
    check("busy_edges", 60'(edges), 60'd30);
    check("vec_42_7_99_10", a_word,
          {4'h0, 7'b1111001, 7'b1000000, 7'b0010000, 7'b0010000,
           BL, 7'b1111000, 7'b0011001, 7'b0100100});

    // 127 overflows to 27; upper bits of port1 ignored (0x85 -> 5).
    set_ports(32'd42, 32'hFFFF_FF85, 32'd99, 32'd127);
    push_exp();
    wait_update(edges);
    check("vec_ovf127", a_word,
          {4'b1000, 7'b0100100, 7'b1111000, 7'b0010000, 7'b0010000,
           BL, 7'b0010010, 7'b0011001, 7'b0100100});

    // 100/109/119/0: mod-100 values with blank tens, ovf on three ports.
    set_ports(32'd100, 32'd109, 32'd119, 32'd0);
    push_exp();
    wait_update(edges);
    check("vec_100_boundary", a_word,
          {4'b0111, BL, 7'b1000000, 7'b1111001, 7'b0010000,
           BL, 7'b0010000, BL, 7'b1000000});

    // port0 12 -> 34 at E5: first commit shows 12, next shows 34.
    set_ports(32'd12, 32'd5, 32'd99, 32'd127);
    push_exp();
    @(posedge clock);              // E0
    repeat (5) @(posedge clock);   // E5
    #1 port0 = 32'd34;
    push_exp();
    begin
      int t;
      t = 0;
      while (a_busy && t < 40) begin
        @(negedge clock);
        t++;
      end
      check("mid_change_lat", 60'(t), 60'd25);
    end
    check("mid_change_12", {46'd0, a_hex1, a_hex0}, {46'd0, 7'b1111001, 7'b0100100});
    wait_update(edges);
    check("mid_change_edges", 60'(edges), 60'd30);
    check("mid_change_34", {46'd0, a_hex1, a_hex0}, {46'd0, 7'b0110000, 7'b0011001});

    // Reset at E15 of a conversion, then a forced re-display.
    set_ports(32'd34, 32'd5, 32'd3, 32'd127);
    @(posedge clock);              // E0
    repeat (14) @(posedge clock);  // E14
    #1 reset = 1'b1;
    @(posedge clock);              // E15
    @(negedge clock);
    check("abort_hex_a", a_word, ALL_BLANK);
    check("abort_hex_b", b_word, ALL_BLANK);
    check("abort_busy", {59'd0, a_busy}, 60'd0);
    push_exp();
    @(posedge clock);
    #1 reset = 1'b0;
    wait_update(edges);
    check("redisplay_edges", 60'(edges), 60'd30);
    check("lz_blank_p2", {46'd0, a_hex5, a_hex4}, {46'd0, BL, 7'b0110000});
    check("lz_zero_p2", {46'd0, b_hex5, b_hex4}, {46'd0, 7'b1000000, 7'b0110000});

    repeat (3) @(negedge clock);
    check("drain_a", 60'(exp_q.size()), 60'd0);
    check("drain_b", 60'(exp2_q.size()), 60'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
